// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg
//   Shared types and constants for the data memory responder:
//   - state_t : responder FSM states (IDLE, WAIT, RESP)
//   - FUNC3_* : RV32I load/store width codes
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

endpackage

// File: rtl/memory_lane_aligner.sv
// memory_lane_aligner
//   Combinational RV32I width/alignment logic for one access.
//   Ports:
//     i_func3       width code of the access
//     i_write       1 = store, 0 = load
//     i_addr_lo     byte offset within the word (addr[1:0])
//     i_store_data  store data, low byte/half used for B/H
//     i_read_word   current contents of the addressed word
//     o_byte_en     byte lanes to write for a store
//     o_store_lanes store data replicated into the byte lanes
//     o_load_data   selected lane(s), sign- or zero-extended
//     o_bad         misaligned access or illegal func3 for this direction
module memory_lane_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic        i_write,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_read_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_store_lanes,
  output logic [31:0] o_load_data,
  output logic        o_bad
);

  // Addressed byte/half moved down to bit 0; only the low half is ever needed.
  logic [15:0] w_shifted;

  assign w_shifted = 16'(i_read_word >> {i_addr_lo, 3'b000});

  always_comb begin
    o_byte_en     = '0;
    o_store_lanes = '0;
    o_load_data   = '0;
    o_bad         = 1'b0;
    unique case (i_func3)
      FUNC3_B: begin
        o_byte_en     = 4'b0001 << i_addr_lo;
        o_store_lanes = {4{i_store_data[7:0]}};
        o_load_data   = {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      FUNC3_BU: begin
        o_bad       = i_write;
        o_load_data = {24'h000000, w_shifted[7:0]};
      end
      FUNC3_H: begin
        o_bad         = i_addr_lo[0];
        o_byte_en     = 4'b0011 << i_addr_lo;
        o_store_lanes = {2{i_store_data[15:0]}};
        o_load_data   = {{16{w_shifted[15]}}, w_shifted};
      end
      FUNC3_HU: begin
        o_bad       = i_addr_lo[0] | i_write;
        o_load_data = {16'h0000, w_shifted};
      end
      FUNC3_W: begin
        o_bad         = |i_addr_lo;
        o_byte_en     = 4'b1111;
        o_store_lanes = i_store_data;
        o_load_data   = i_read_word;
      end
      default: begin
        o_bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Multi-cycle byte-addressed data memory answering RV32I loads/stores over
//   valid/ready request and response channels, one request outstanding.
//   Ports:
//     clock, reset          rising-edge clock, synchronous active-high reset
//     reqValid/reqReady     request handshake (ready only in IDLE)
//     reqWrite, reqFunc3    store/load and width code, captured on accept
//     reqAddress            byte address, captured on accept
//     reqWriteData          store data, captured on accept
//     respValid/respReady   response handshake
//     respReadData          load result (0 for stores and errors)
//     respError             misaligned, out of range or illegal func3
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunc3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respReadData,
  output logic        respError
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  COUNT_INIT = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_count;
  logic        r_write;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_read_word;
  logic [3:0]       w_byte_en;
  logic [31:0]      w_store_lanes;
  logic [31:0]      w_load_data;
  logic             w_bad;
  logic             w_error;
  logic             w_eval;
  logic             w_commit;

  assign w_in_range  = (r_addr < BYTE_LIMIT);
  assign w_idx       = r_addr[IDX_W+1:2];
  // Guarded read keeps an out-of-range index from reaching the array.
  assign w_read_word = w_in_range ? r_mem[w_idx] : '0;
  assign w_error     = w_bad | ~w_in_range;
  assign w_eval      = (r_state == WAIT) && (r_count == '0);
  assign w_commit    = w_eval && r_write && !w_error;

  assign respReadData = r_rdata;
  assign respError    = r_err;

  memory_lane_aligner u_aligner (
    .i_func3       (r_func3),
    .i_write       (r_write),
    .i_addr_lo     (r_addr[1:0]),
    .i_store_data  (r_wdata),
    .i_read_word   (w_read_word),
    .o_byte_en     (w_byte_en),
    .o_store_lanes (w_store_lanes),
    .o_load_data   (w_load_data),
    .o_bad         (w_bad)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    reqReady     = 1'b0;
    respValid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) w_next_state = WAIT;
      end
      WAIT: begin
        if (r_count == '0) w_next_state = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        if (respReady) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_write <= 1'b0;
      r_func3 <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (r_state == IDLE && reqValid) begin
        r_write <= reqWrite;
        r_func3 <= reqFunc3;
        r_addr  <= reqAddress;
        r_wdata <= reqWriteData;
        r_count <= COUNT_INIT;
      end else if (r_state == WAIT && r_count != '0) begin
        r_count <= r_count - 4'd1;
      end

      if (w_eval) begin
        r_err   <= w_error;
        r_rdata <= (w_error || r_write) ? '0 : w_load_data;
      end

      // Store commits only on the evaluation edge, so stalls never rewrite it.
      if (w_commit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (w_byte_en[b]) r_mem[w_idx][8*b +: 8] <= w_store_lanes[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;
  localparam int unsigned BYTES = 4 * DEPTH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [2:0]  reqFunc3 = '0;
  logic [31:0] reqAddress = '0;
  logic [31:0] reqWriteData = '0;
  logic        respValid;
  logic        respReady = 1'b0;
  logic [31:0] respReadData;
  logic        respError;

  always #5 clock = ~clock;

  data_memory_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqFunc3     (reqFunc3),
    .reqAddress   (reqAddress),
    .reqWriteData (reqWriteData),
    .respValid    (respValid),
    .respReady    (respReady),
    .respReadData (respReadData),
    .respError    (respError)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference memory: plain byte array, byte address = index.
  logic [7:0]  model_mem [BYTES];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data  = '0;
  logic        exp_err   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void clear_model();
    for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
  endfunction

  function automatic void model_access(input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic err);
    int unsigned size;
    logic        legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err   = !legal || (a % size != 0) || (a >= BYTES);
    rd    = '0;
    v     = '0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < int'(size); i++) model_mem[a + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(size); i++) v[8*i +: 8] = model_mem[a + i];
        rd = v;
        if (!f3[2] && size == 1 && v[7])  rd = v | 32'hFFFFFF00;
        if (!f3[2] && size == 2 && v[15]) rd = v | 32'hFFFF0000;
      end
    end
  endfunction

  // Every cycle a response is due, it must match the model and be held.
  always @(negedge clock) begin
    if (!reset) begin
      if (exp_valid && respValid) begin
        chk("resp_data", respReadData, exp_data);
        chk("resp_error", {31'd0, respError}, {31'd0, exp_err});
        chk("req_ready_busy", {31'd0, reqReady}, 32'd0);
      end else if (!exp_valid) begin
        chk("resp_idle", {31'd0, respValid}, 32'd0);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int unsigned stall,
                        output logic [31:0] got_d, output logic got_e);
    logic [31:0] md;
    logic        me;
    int unsigned waited;
    got_d = '0;
    got_e = 1'b0;
    @(negedge clock);
    chk("req_ready_idle", {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWrite = wr; reqFunc3 = f3; reqAddress = a; reqWriteData = d;
    @(posedge clock);
    model_access(wr, f3, a, d, md, me);
    exp_data = md; exp_err = me; exp_valid = 1'b1;
    #1;
    reqValid = 1'b0;
    reqWrite = 1'($urandom); reqFunc3 = 3'($urandom);
    reqAddress = $urandom; reqWriteData = $urandom;
    @(negedge clock);
    waited = 0;
    while (!respValid && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    chk("latency", waited, LAT);
    if (!respValid) begin
      exp_valid = 1'b0;
      return;
    end
    for (int unsigned s = 0; s < stall; s++) begin
      @(negedge clock);
      chk("resp_held", {31'd0, respValid}, 32'd1);
    end
    got_d = respReadData;
    got_e = respError;
    respReady = 1'b1;
    @(posedge clock);
    #1;
    respReady = 1'b0;
    exp_valid = 1'b0;
    chk("retired_valid", {31'd0, respValid}, 32'd0);
    chk("retired_ready", {31'd0, reqReady}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] gd;
    logic        ge;
    logic [31:0] a;
    clear_model();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_req_ready", {31'd0, reqReady}, 32'd1);
    chk("rst_resp_valid", {31'd0, respValid}, 32'd0);
    chk("rst_data", respReadData, 32'd0);
    chk("rst_error", {31'd0, respError}, 32'd0);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, gd, ge);
    chk("sw_data", gd, 32'h0);
    chk("sw_err", {31'd0, ge}, 32'd0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, gd, ge);
    chk("lw_10", gd, 32'hDEADBEEF);
    chk("lw_10_err", {31'd0, ge}, 32'd0);

    do_req(1'b1, 3'b000, 32'h21, 32'hABCDEF80, 0, gd, ge);
    do_req(1'b0, 3'b000, 32'h21, 32'h0, 0, gd, ge);
    chk("lb_21", gd, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h21, 32'h0, 0, gd, ge);
    chk("lbu_21", gd, 32'h00000080);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, gd, ge);
    chk("lw_20", gd, 32'h00008000);

    do_req(1'b1, 3'b001, 32'h32, 32'h99991234, 0, gd, ge);
    do_req(1'b0, 3'b101, 32'h32, 32'h0, 0, gd, ge);
    chk("lhu_32", gd, 32'h00001234);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 0, gd, ge);
    chk("lw_30", gd, 32'h12340000);

    do_req(1'b0, 3'b010, 32'h13, 32'h0, 0, gd, ge);
    chk("lw_13_err", {31'd0, ge}, 32'd1);
    chk("lw_13_data", gd, 32'h0);
    do_req(1'b1, 3'b010, 32'h402, 32'hCAFEF00D, 0, gd, ge);
    chk("sw_402_err", {31'd0, ge}, 32'd1);
    do_req(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 0, gd, ge);
    chk("sw_400_err", {31'd0, ge}, 32'd1);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 0, gd, ge);
    chk("lw_0_untouched", gd, 32'h0);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 0, gd, ge);
    chk("lw_3fc_err", {31'd0, ge}, 32'd0);

    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, gd, ge);
    chk("stall_lw_10", gd, 32'hDEADBEEF);

    // Reset while the store is still waiting: it must never land.
    @(negedge clock);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunc3 = 3'b010;
    reqAddress = 32'h40; reqWriteData = 32'h55;
    @(posedge clock);
    #1;
    reqValid = 1'b0;
    @(negedge clock);
    chk("abort_busy", {31'd0, reqReady}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_req_ready", {31'd0, reqReady}, 32'd1);
    chk("abort_resp_valid", {31'd0, respValid}, 32'd0);
    chk("abort_data", respReadData, 32'd0);
    chk("abort_error", {31'd0, respError}, 32'd0);
    clear_model();
    @(negedge clock);
    reset = 1'b0;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 0, gd, ge);
    chk("lw_40_after_abort", gd, 32'h0);
    chk("lw_40_err", {31'd0, ge}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h3F8 + $urandom_range(0, 15);
        1:       a = $urandom;
        default: begin
          a = $urandom_range(0, 127);
          if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
        end
      endcase
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 3), gd, ge);
    end

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Byte-addressed data memory that answers load/store requests from the processor's memory-access stage through a valid/ready request channel and a valid/ready response channel. It replaces the single-cycle combinational data memory with a multi-cycle responder. The pipeline acts as initiator and this block as responder. It applies RV32I load/store width and sign rules from func3, and reports misaligned, out-of-range and illegal-func3 requests as errors instead of corrupting memory.

## Interface
- DEPTH_WORDS, 256: storage size in 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- reqValid  in  1  request present.
- reqReady  out  1  responder can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqFunc3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- reqAddress  in  32  byte address.
- reqWriteData  in  32  store data; low byte or half is used for B/H.
- respValid  out  1  response present.
- respReady  in  1  initiator takes the response.
- respReadData  out  32  load result, extended to 32 bits; 0 for stores and errors.
- respError  out  1  request was misaligned, out of range, or had an illegal func3.

## Operation
- FSM states:
  - IDLE: reqReady=1. On reqValid, capture write, func3, address and data, load the wait counter with LATENCY-1, and go to WAIT.
  - WAIT: reqReady=0. Decrement the counter each cycle. When the counter is 0, evaluate the request and go to RESP.
  - RESP: respValid=1. respReadData and respError are held stable. On respReady, go to IDLE.
- Evaluation takes place on the WAIT→RESP edge.
- Error checks:
  - Illegal func3 for a load: 011, 110, 111.
  - Illegal func3 for a store: anything other than 000, 001, 010.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0.
  - Out of range: address ≥ 4*DEPTH_WORDS.
- On error: no write, respReadData=0, respError=1.
- Store: byte-lane write into word addr[31:2], lane addr[1:0]. SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes. Other bytes are untouched.
- Load: select lane(s). B and H are sign-extended; BU and HU are zero-extended.
- Memory is little-endian: byte 0 is word bits [7:0].
- Only one request is outstanding at a time. reqReady is 0 in WAIT and RESP, so a new request is never accepted in the same cycle a response retires.

## Timing
- Reset values: state IDLE, reqReady=1, respValid=0, respReadData=0, respError=0, counter 0. All memory words are 0.
- Reset held for 1 cycle is sufficient. All words clear in that cycle.
- Latency: request accepted at edge k gives respValid=1 after edge k+LATENCY. LATENCY=1 means the response is visible one cycle after acceptance.
- Store commits at edge k+LATENCY, exactly once, even if respReady stalls.
- A load issued after a store's response has retired sees the stored data.
- Backpressure: respValid stays 1 and the data stays stable until respReady=1 is sampled. The FSM returns to IDLE on that edge. reqReady becomes 1 the following cycle.
- Reset mid-operation (WAIT or RESP) aborts the request. An uncommitted store is never written. All outputs return to reset values on the same edge.
- Inputs reqAddress, reqFunc3, reqWrite and reqWriteData are sampled only at acceptance. Later changes are ignored.

## Structure
- Package data_memory_responder_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - func3 constants (FUNC3_B, FUNC3_H, FUNC3_W, FUNC3_BU, FUNC3_HU).
- The existing dataMemory should adopt the same func3 constants.
- Sub-module memory_lane_aligner is combinational. From func3, addr[1:0], store data and the read word, it produces:
  - 4-bit byte-enable;
  - store word shifted into lanes;
  - extended load result;
  - misaligned/illegal flag.
- The top holds the FSM, counter, capture registers, range check and storage array.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → respReadData=0xDEADBEEF, respError=0. respValid rises LATENCY cycles after each acceptance.
- SB 0x80 @0x21, then LB @0x21 → 0xFFFFFF80. LBU @0x21 → 0x00000080. LW @0x20 → 0x00008000.
- SH 0x1234 @0x32, then LHU @0x32 → 0x00001234. LW @0x30 → 0x12340000.
- LW @0x13 → respError=1, data 0. SW @0x402 (DEPTH_WORDS=256) → respError=1, and memory is unchanged, checked by readback.
- Hold respReady=0 for 5 cycles → respValid held and data stable, reqReady=0 throughout. The response retires on the first respReady=1, and reqReady=1 the next cycle.
- Assert reset during WAIT of SW 0x55 @0x40 → outputs reset that edge, and a subsequent LW @0x40 → 0x00000000.
